// File: rtl/vdma_arbiter.sv
// vdma_arbiter
// Shares one asynchronous 16-bit SRAM port between the bilevel VGA
// controller's pixel DMA and the CPU. Video fetches win over the CPU and the
// arbiter owns the video word-address counter. A fetch takes a single SRAM
// cycle, so it finishes well inside the controller's 8-clock word period.
//
// Build option:
//   VDMA_WRAP_EN  when defined, the video address reloads VBASE after the
//                 last word of the frame (VBASE+VWORDS-1). When undefined it
//                 counts freely modulo 2^AW and only vreset/rst reload it.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   vreq              video fetch request pulse
//   vreset            restart the video address at VBASE (pulse)
//   vack, pixels      video data valid pulse and fetched word
//   vovr              sticky video overrun flag (request dropped)
//   cpu_req, cpu_we   CPU access request (level) and write select
//   cpu_addr          CPU word address
//   cpu_wdata         CPU write data
//   cpu_rdy           CPU access done pulse
//   cpu_rdata         CPU read data, valid with cpu_rdy
//   mem_addr, mem_oe, mem_we, mem_wdata   registered SRAM controls
//   mem_rdata         SRAM read data, valid by the end of the access cycle
module vdma_arbiter #(
    parameter int             AW     = 16,
    parameter logic [AW-1:0]  VBASE  = 16'h8000,
    parameter int             VWORDS = 16380
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vreq,
    input  logic          vreset,
    output logic          vack,
    output logic [15:0]   pixels,
    output logic          vovr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_rdy,
    output logic [15:0]   cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_VID  = 2'd1;
    localparam logic [1:0] S_CPU  = 2'd2;

`ifdef VDMA_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [AW-1:0] VLAST = VBASE + AW'(VWORDS - 1);

    logic [1:0]    state_q, state_d;
    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    logic          vack_q;
    logic [15:0]   pixels_q;
    logic          vovr_q, vovr_d;
    logic          cpu_rdy_q;
    logic [15:0]   cpu_rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_oe_q;
    logic          mem_we_q;
    logic [15:0]   mem_wdata_q;

    logic vidNow;
    logic cpuNew;

    // Next-state selection. A VID cycle is never followed directly by another
    // VID: a request arriving during a fetch stays pending and is served after
    // one non-video cycle, which gives a waiting CPU access a slot. A request
    // arriving while one is already pending outside a VID cycle is an overrun
    // and is dropped. The video address counts up when a fetch completes,
    // wrapping at the end of the frame when the wrap option is built in;
    // vreset takes precedence over both.
    always_comb begin
        vidNow  = (state_q == S_VID);
        cpuNew  = cpu_req && (state_q != S_CPU) && !cpu_rdy_q;
        vpend_d = vidNow ? vreq : (vpend_q || vreq);
        vovr_d  = vovr_q || (vreq && vpend_q && !vidNow);

        if ((vpend_q || vreq) && !vidNow) begin
            state_d = S_VID;
        end else if (cpuNew) begin
            state_d = S_CPU;
        end else begin
            state_d = S_IDLE;
        end

        vaddr_d = vaddr_q;
        if (vidNow) begin
            if (WRAP_EN && (vaddr_q == VLAST)) begin
                vaddr_d = VBASE;
            end else begin
                vaddr_d = vaddr_q + 1'b1;
            end
        end
        if (vreset) begin
            vaddr_d = VBASE;
        end
    end

    // Arbiter state, video bookkeeping and completion pulses. The SRAM
    // controls are registered from the chosen next state so that they are
    // valid for the whole access cycle; in IDLE the address and write data
    // simply hold. Read data is captured at the edge that ends the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vpend_q     <= 1'b0;
            vaddr_q     <= VBASE;
            vack_q      <= 1'b0;
            pixels_q    <= '0;
            vovr_q      <= 1'b0;
            cpu_rdy_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            vpend_q   <= vpend_d;
            vaddr_q   <= vaddr_d;
            vovr_q    <= vovr_d;
            vack_q    <= vidNow;
            cpu_rdy_q <= (state_q == S_CPU);

            if (vidNow) begin
                pixels_q <= mem_rdata;
            end
            if ((state_q == S_CPU) && !mem_we_q) begin
                cpu_rdata_q <= mem_rdata;
            end

            case (state_d)
                S_VID: begin
                    mem_addr_q <= vaddr_d;
                    mem_oe_q   <= 1'b1;
                    mem_we_q   <= 1'b0;
                end
                S_CPU: begin
                    mem_addr_q  <= cpu_addr;
                    mem_wdata_q <= cpu_wdata;
                    mem_oe_q    <= !cpu_we;
                    mem_we_q    <= cpu_we;
                end
                default: begin
                    mem_oe_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign vack      = vack_q;
    assign pixels    = pixels_q;
    assign vovr      = vovr_q;
    assign cpu_rdy   = cpu_rdy_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vdma_arbiter.sv
// tb_vdma_arbiter
// Directed bench for vdma_arbiter. The SRAM model returns 16'hA5C3 at the
// frame base and addr^16'h5A5A everywhere else. The DUT is built with
// VWORDS=4 so the frame-wrap option can be seen within a few fetches.
module tb_vdma_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vreq, vreset;
    logic        vack;
    logic [15:0] pixels;
    logic        vovr;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_oe, mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int assertCount = 0;
    int failCount   = 0;

`ifdef VDMA_WRAP_EN
    localparam logic [15:0] WRAP_ADDR = 16'h8000;
    localparam logic [15:0] WRAP_PIX  = 16'hA5C3;
`else
    localparam logic [15:0] WRAP_ADDR = 16'h8004;
    localparam logic [15:0] WRAP_PIX  = 16'hDA5E;
`endif

    vdma_arbiter #(.AW(16), .VBASE(16'h8000), .VWORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .vreq      (vreq),
        .vreset    (vreset),
        .vack      (vack),
        .pixels    (pixels),
        .vovr      (vovr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdy   (cpu_rdy),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Asynchronous SRAM model.
    assign mem_rdata = (mem_addr == 16'h8000) ? 16'hA5C3 : (mem_addr ^ 16'h5A5A);

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vq, input logic vr, input logic cr,
                                 input logic cw, input logic [15:0] ca,
                                 input logic [15:0] cd);
        vreq      = vq;
        vreset    = vr;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
    endtask

    task automatic applyReset;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        applyReset();

        // Reset state
        checkOutput("rst_oe",    mem_oe,   0);
        checkOutput("rst_we",    mem_we,   0);
        checkOutput("rst_vack",  vack,     0);
        checkOutput("rst_rdy",   cpu_rdy,  0);
        checkOutput("rst_vovr",  vovr,     0);
        checkOutput("rst_addr",  mem_addr, 0);
        tick();
        checkOutput("idle_oe",   mem_oe,   0);

        // vreset + vreq: fetch from frame base
        applyStimulus(1, 1, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        checkOutput("v0_addr",   mem_addr, 16'h8000);
        checkOutput("v0_oe",     mem_oe,   1);
        checkOutput("v0_we",     mem_we,   0);
        tick();
        checkOutput("v0_vack",   vack,     1);
        checkOutput("v0_pix",    pixels,   16'hA5C3);
        checkOutput("v0_oe_off", mem_oe,   0);
        tick();
        checkOutput("v0_vack_1p", vack,    0);
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        checkOutput("v1_addr",   mem_addr, 16'h8001);
        tick();
        checkOutput("v1_vack",   vack,     1);
        checkOutput("v1_pix",    pixels,   16'hDA5B);
        tick();

        // CPU read and vreq together: video first, CPU next
        applyStimulus(1, 0, 1, 0, 16'h0100, 16'h0);
        tick();
        vreq = 1'b0;
        checkOutput("vc_vid_addr", mem_addr, 16'h8002);
        checkOutput("vc_vid_oe",   mem_oe,   1);
        tick();
        checkOutput("vc_vack",     vack,     1);
        checkOutput("vc_pix",      pixels,   16'hDA58);
        checkOutput("vc_cpu_addr", mem_addr, 16'h0100);
        checkOutput("vc_cpu_oe",   mem_oe,   1);
        checkOutput("vc_cpu_we",   mem_we,   0);
        checkOutput("vc_rdy_early", cpu_rdy, 0);
        tick();
        cpu_req = 1'b0;
        checkOutput("vc_rdy",      cpu_rdy,  1);
        checkOutput("vc_rdata",    cpu_rdata, 16'h5B5A);
        checkOutput("vc_idle_oe",  mem_oe,   0);
        tick();
        checkOutput("vc_rdy_1p",   cpu_rdy,  0);

        // CPU write held one extra cycle
        applyStimulus(0, 0, 1, 1, 16'h0200, 16'h1234);
        tick();
        checkOutput("wr_we",    mem_we,    1);
        checkOutput("wr_oe",    mem_oe,    0);
        checkOutput("wr_addr",  mem_addr,  16'h0200);
        checkOutput("wr_data",  mem_wdata, 16'h1234);
        tick();
        cpu_req = 1'b0;
        checkOutput("wr_rdy",   cpu_rdy,   1);
        checkOutput("wr_we_off", mem_we,   0);
        checkOutput("wr_rdata_hold", cpu_rdata, 16'h5B5A);
        tick();
        checkOutput("wr_rdy_once", cpu_rdy, 0);
        checkOutput("wr_we_once",  mem_we,  0);
        checkOutput("idle_addr_hold", mem_addr,  16'h0200);
        checkOutput("idle_data_hold", mem_wdata, 16'h1234);

        // Overrun: requests in the VID cycle and the following CPU cycle
        applyStimulus(1, 0, 1, 0, 16'h0300, 16'h0);
        tick();
        checkOutput("ov_vid_addr", mem_addr, 16'h8003);
        tick();
        checkOutput("ov_vack0",    vack,     1);
        checkOutput("ov_cpu_addr", mem_addr, 16'h0300);
        checkOutput("ov_vovr_pre", vovr,     0);
        tick();
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        checkOutput("ov_vovr",     vovr,     1);
        checkOutput("ov_wrap_addr", mem_addr, WRAP_ADDR);
        checkOutput("ov_rdy",      cpu_rdy,  1);
        checkOutput("ov_rdata",    cpu_rdata, 16'h595A);
        checkOutput("ov_vack_gap", vack,     0);
        tick();
        checkOutput("ov_vack1",    vack,     1);
        checkOutput("ov_pix",      pixels,   WRAP_PIX);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("ov_no_extra_vack", vack, 0);
            checkOutput("ov_sticky",        vovr, 1);
        end
        applyReset();
        checkOutput("ov_rst_clear", vovr, 0);

        // Reset in the middle of a CPU write abandons it
        applyStimulus(0, 0, 1, 1, 16'h0400, 16'hBEEF);
        tick();
        checkOutput("ma_we", mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ma_we_async", mem_we, 0);
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("ma_no_rdy", cpu_rdy, 0);

        // vreset during a fetch: old data delivered, next fetch from base
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h0);
        checkOutput("vr_addr", mem_addr, 16'h8000);
        tick();
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0);
        checkOutput("vr_vack", vack,   1);
        checkOutput("vr_pix",  pixels, 16'hA5C3);
        tick();
        vreq = 1'b0;
        checkOutput("vr_next_addr", mem_addr, 16'h8000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vdma_arbiter.md
Name: vdma_arbiter

Overview:
- Shares one asynchronous 16-bit SRAM port between the bilevel VGA controller's pixel DMA and the CPU.
- Serves video fetches ahead of the CPU and owns the video word-address counter.
- Sits between the VGA controller (vreq/vreset/vack/pixels) and the external memory interface.
- Guarantees a video fetch completes well inside the controller's 8-clock word period.

Parameters:
- AW, 16, word address width.
- VBASE, 16'h8000, frame buffer base word address; value loaded by vreset.
- VWORDS, 16380, frame length in words (576x455/16); used only with VDMA_WRAP_EN.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous reset, active-high
- vreq  in  1  video fetch request, single-cycle pulse
- vreset  in  1  restart video address at VBASE, single-cycle pulse
- vack  out  1  video data valid, one-cycle pulse
- pixels  out  16  video data, valid when vack=1
- vovr  out  1  sticky video overrun flag
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1=write, 0=read; held with cpu_req
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_rdy  out  1  CPU access done, one-cycle pulse
- cpu_rdata  out  16  CPU read data, valid when cpu_rdy=1
- mem_addr  out  AW  SRAM address, registered
- mem_oe  out  1  SRAM output enable, registered
- mem_we  out  1  SRAM write enable, registered
- mem_wdata  out  16  SRAM write data, registered
- mem_rdata  in  16  SRAM read data; valid by end of access cycle

Behaviour:
- Reset (async):
  - state=IDLE; vpend=0; vaddr=VBASE.
  - vack, cpu_rdy, vovr, mem_oe, mem_we = 0; pixels, cpu_rdata, mem_addr, mem_wdata = 0.
  - Reset mid-access abandons that access; no vack or cpu_rdy follows.
- State machine: IDLE, VID, CPU. Each state lasts exactly one cycle, and a new state is chosen every clock.
- Next-state rule, in priority order:
  - (vpend or vreq) and not finishing that same fetch -> VID.
  - Else a new CPU request -> CPU.
  - Else -> IDLE.
- A new CPU request is cpu_req=1 with state!=CPU and cpu_rdy=0. A CPU access therefore completes at most every other cycle.
- VID cycle:
  - mem_addr=vaddr, mem_oe=1.
  - At the edge ending VID: pixels<=mem_rdata; vack=1 for the next cycle; vaddr<=vaddr+1 mod 2^AW; vpend cleared unless a new vreq arrives in that cycle.
- CPU cycle:
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_oe=~cpu_we, mem_we=cpu_we.
  - Next cycle: cpu_rdy=1; cpu_rdata=mem_rdata for reads, unchanged for writes.
- Video latency: vreq high in cycle N -> VID in N+1 (or N+2 if a CPU access is issued in N+1) -> vack in N+2, worst case N+3.
- vreq while vpend=1 and no VID this cycle -> vovr<=1, sticky until rst; the extra request is dropped.
- vreset:
  - vaddr<=VBASE; this overrides the increment of a VID completing in the same cycle.
  - The in-flight VID still delivers its vack with the old-address data.
  - vreset with vreq: the pending fetch reads VBASE.
- CPU starvation is impossible: video occupies at most 1 of every 8 cycles.
- mem_oe and mem_we are never both 1.
- In IDLE: mem_oe=mem_we=0; mem_addr and mem_wdata hold their previous values.

Optional Feature:
- VDMA_WRAP_EN defined: when a VID completes with vaddr==VBASE+VWORDS-1, vaddr<=VBASE, so a missing vreset cannot run past the frame.
- VDMA_WRAP_EN undefined: vaddr increments freely modulo 2^AW; only vreset or rst reloads it.

Test Plan:
- rst then idle -> vaddr=16'h8000; mem_oe, mem_we, vack, cpu_rdy all 0; vovr=0.
- vreset+vreq in cycle 0, memory returns 16'hA5C3 -> mem_addr=16'h8000 with mem_oe=1 in cycle 1; vack=1 and pixels=16'hA5C3 in cycle 2; next fetch uses 16'h8001.
- cpu_req read at 16'h0100 held, vreq pulsed the same cycle -> VID issued first, CPU access next cycle; cpu_rdy one cycle later with the mem_rdata value; vack within 3 cycles of vreq.
- cpu_we=1, addr 16'h0200, data 16'h1234 -> exactly one cycle with mem_we=1 and mem_addr=16'h0200, mem_wdata=16'h1234; cpu_rdy pulses once even if cpu_req stays high one extra cycle.
- Two vreq pulses one cycle apart while a CPU access is issued -> vovr=1 and stays 1; exactly one vack; reset clears vovr.
- VDMA_WRAP_EN, VWORDS=4 -> fetch addresses 8000, 8001, 8002, 8003, 8000. Without the macro -> 8004 follows 8003.
